// File: rtl/fmd_seq_ctrl.sv
// fmd_seq_ctrl -- sequencer for the shared significand multiply/divide
// datapath (multiplier tree, reciprocal ROM, Newton-Raphson operand muxes,
// fd select register).
//
// Accepts one operation at a time. A multiply is a single multiplier pass
// followed by the done pulse. A divide walks ROM lookup, ITER_SP/ITER_DP
// Newton-Raphson iterations (an A pass then an X pass each), a quotient
// pass, a remainder pass and a one-cycle select before done.
//
// Every multiplier pass lasts MUL_LAT cycles; the register write enable of
// a pass fires only on its last cycle, so the product is stable by then.
//
// Optional build macro: FMD_SEQ_ABORT_EN
//    When defined, an extra input 'abort' returns the sequencer to IDLE
//    from any busy state on the next edge, suppressing done and all write
//    enables from the abort cycle onwards. A start seen in IDLE is not
//    affected by abort.
//    When undefined there is no abort port and every accepted operation
//    runs through to DONE.

module fmd_seq_ctrl #(
   parameter int MUL_LAT = 2,
   parameter int ITER_SP = 2,
   parameter int ITER_DP = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       fdiv,
   input  logic       db,
`ifdef FMD_SEQ_ABORT_EN
   input  logic       abort,
`endif
   output logic       busy,
   output logic       done,
   output logic [1:0] oe1,
   output logic       oe2,
   output logic [1:0] a_sel,
   output logic [1:0] b_sel,
   output logic       x_we,
   output logic       a_we,
   output logic       q_we,
   output logic       fq_we,
   output logic [1:0] iter_left
);

   // Pass counter width: at least one bit even for single-cycle passes.
   localparam int              PCW       = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
   localparam logic [PCW-1:0]  PC_LAST   = PCW'(MUL_LAT - 1);
   localparam logic [PCW-1:0]  PC_ONE    = PCW'(1);
   localparam logic [1:0]      ITER_SP_C = 2'(ITER_SP);
   localparam logic [1:0]      ITER_DP_C = 2'(ITER_DP);

   // Operand mux codes for the multiplier inputs.
   localparam logic [1:0] A_SEED  = 2'd0;
   localparam logic [1:0] A_X     = 2'd1;
   localparam logic [1:0] A_FA    = 2'd2;
   localparam logic [1:0] A_E     = 2'd3;
   localparam logic [1:0] B_FB    = 2'd0;
   localparam logic [1:0] B_TWO_A = 2'd1;
   localparam logic [1:0] B_X     = 2'd2;

   typedef enum logic [3:0] {
      S_IDLE,
      S_MUL,
      S_LOOKUP,
      S_NR_A,
      S_NR_X,
      S_QUOT,
      S_REM,
      S_SEL,
      S_DONE
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [PCW-1:0]   pc;
   logic [PCW-1:0]   pc_nxt;
   logic [1:0]       iter_nxt;
   logic             op_db;
   logic             op_db_nxt;
   logic             pc_last;
   logic             first_iter;

   // The operation type needs no register of its own: the branch taken out
   // of IDLE (MUL versus LOOKUP) already records it for the rest of the run.
   // Precision is kept because it decides which iteration is the first one.
   assign pc_last    = (pc == PC_LAST);
   assign first_iter = (iter_left == (op_db ? ITER_DP_C : ITER_SP_C));

   // State register, pass counter, iteration count and latched precision.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         pc        <= '0;
         iter_left <= 2'd0;
         op_db     <= 1'b0;
      end else begin
         state     <= state_nxt;
         pc        <= pc_nxt;
         iter_left <= iter_nxt;
         op_db     <= op_db_nxt;
      end
   end

   // Next-state sequencing and per-state datapath controls.
   always_comb begin
      state_nxt = state;
      pc_nxt    = '0;
      iter_nxt  = iter_left;
      op_db_nxt = op_db;
      busy      = (state != S_IDLE);
      done      = 1'b0;
      oe1       = 2'b00;
      oe2       = 1'b0;
      a_sel     = A_SEED;
      b_sel     = B_FB;
      x_we      = 1'b0;
      a_we      = 1'b0;
      q_we      = 1'b0;
      fq_we     = 1'b0;

      case (state)
         S_IDLE: begin
            if (start) begin
               op_db_nxt = db;
               iter_nxt  = db ? ITER_DP_C : ITER_SP_C;
               state_nxt = fdiv ? S_LOOKUP : S_MUL;
            end
         end

         S_MUL: begin
            a_sel = A_FA;
            b_sel = B_FB;
            if (pc_last) begin
               fq_we     = 1'b1;
               state_nxt = S_DONE;
            end else begin
               pc_nxt = pc + PC_ONE;
            end
         end

         S_LOOKUP: begin
            oe1       = 2'b11;
            state_nxt = S_NR_A;
         end

         S_NR_A: begin
            oe1   = 2'b11;
            a_sel = first_iter ? A_SEED : A_X;
            b_sel = B_FB;
            if (pc_last) begin
               a_we      = 1'b1;
               state_nxt = S_NR_X;
            end else begin
               pc_nxt = pc + PC_ONE;
            end
         end

         S_NR_X: begin
            oe1   = 2'b10;
            oe2   = 1'b1;
            a_sel = first_iter ? A_SEED : A_X;
            b_sel = B_TWO_A;
            if (pc_last) begin
               x_we = 1'b1;
               if (iter_left > 2'd1) begin
                  iter_nxt  = iter_left - 2'd1;
                  state_nxt = S_NR_A;
               end else begin
                  iter_nxt  = 2'd0;
                  state_nxt = S_QUOT;
               end
            end else begin
               pc_nxt = pc + PC_ONE;
            end
         end

         S_QUOT: begin
            oe1   = 2'b01;
            oe2   = 1'b1;
            a_sel = A_FA;
            b_sel = B_X;
            if (pc_last) begin
               q_we      = 1'b1;
               state_nxt = S_REM;
            end else begin
               pc_nxt = pc + PC_ONE;
            end
         end

         S_REM: begin
            oe1   = 2'b01;
            a_sel = A_E;
            b_sel = B_FB;
            if (pc_last) begin
               a_we      = 1'b1;
               state_nxt = S_SEL;
            end else begin
               pc_nxt = pc + PC_ONE;
            end
         end

         S_SEL: begin
            fq_we     = 1'b1;
            state_nxt = S_DONE;
         end

         S_DONE: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end

         default: begin
            state_nxt = S_IDLE;
         end
      endcase

`ifdef FMD_SEQ_ABORT_EN
      // An abort in a busy state kills the pass in flight: nothing is
      // written this cycle and the sequencer is idle from the next edge.
      if (abort && (state != S_IDLE)) begin
         state_nxt = S_IDLE;
         pc_nxt    = '0;
         iter_nxt  = 2'd0;
         done      = 1'b0;
         x_we      = 1'b0;
         a_we      = 1'b0;
         q_we      = 1'b0;
         fq_we     = 1'b0;
      end
`endif
   end

endmodule

// File: doc/fmd_seq_ctrl.md
Name: fmd_seq_ctrl

Overview:
- Clocked sequencer for the shared significand multiply/divide datapath (multiplier tree, reciprocal ROM, Newton-Raphson operand muxes, fd select).
- Accepts one operation at a time and steps the multiplier through the ordered passes: plain multiply, or ROM seed, Newton-Raphson iterations, quotient, remainder, select.
- Generates oe1/oe2 codes, operand-mux selects and register write enables. Signals completion with a one-cycle done pulse.

Parameters:
- MUL_LAT, 2, cycles per multiplier pass (>=1); write enable fires on last cycle of pass
- ITER_SP, 2, Newton-Raphson iterations for single precision
- ITER_DP, 3, Newton-Raphson iterations for double precision

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  request; accepted only when busy=0
- fdiv  in  1  1=divide, 0=multiply; sampled with start
- db  in  1  1=double precision; sampled with start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- oe1  out  2  datapath phase code
- oe2  out  1  datapath phase code
- a_sel  out  2  mult A operand: 0 seed {01,lut,0}, 1 x_reg, 2 {fa,00000}, 3 E_reg
- b_sel  out  2  mult B operand: 0 {fb,00000}, 1 ~A_reg (2-A), 2 x_reg
- x_we  out  1  load x_reg from product
- a_we  out  1  load A_reg from product
- q_we  out  1  load q/E_reg from product
- fq_we  out  1  load fq output register
- iter_left  out  2  remaining Newton-Raphson iterations

Behaviour:
- Reset: state=IDLE. busy, done, all *_we = 0. oe1=00, oe2=0, a_sel=0, b_sel=0, iter_left=0. Reset mid-operation aborts with no done.
- Accept: in IDLE with start=1, latch op_div=fdiv and op_db=db. iter_left = op_db ? ITER_DP : ITER_SP. Start is ignored while busy=1.
- Pass counter pc: counts 0..MUL_LAT-1 in each multiply state and clears on state change. Write enables are high only when pc=MUL_LAT-1.
- States, with outputs (oe1/oe2, a_sel/b_sel, we) and transitions:
  - IDLE: outputs 00/0, 0/0. Goes to LOOKUP if op_div, else MUL.
  - MUL: 00/0, a=2, b=0. fq_we on the last cycle. Then DONE.
  - LOOKUP: 11/0. One cycle for the ROM read. Then NR_A.
  - NR_A: 11/0, a = (first iteration ? 0 : 1), b=0. a_we on the last cycle. Then NR_X.
  - NR_X: 10/1, a=1 except first iteration a=0, b=1. x_we on the last cycle. iter_left decrements on the same edge. Goes to NR_A if the new iter_left>0, else QUOT.
  - QUOT: 01/1, a=2, b=2. q_we on the last cycle. Then REM.
  - REM: 01/0, a=3, b=0. a_we on the last cycle. Then SEL.
  - SEL: 00/0. fq_we held for 1 cycle. Then DONE.
  - DONE: done=1 for 1 cycle. Then IDLE.
- Latency, as edges from the start-sampling edge to the cycle where done is high:
  - Multiply: MUL_LAT+1 (3 at default).
  - Divide: 3+(2*ITER+2)*MUL_LAT, giving 15 for SP and 19 for DP at default.
- Back-to-back: a start in the DONE cycle is ignored. A start in the following IDLE cycle is accepted.
- fdiv/db changing mid-operation has no effect; the latched values are used.
- iter_left never underflows. It holds 0 outside NR states after the final decrement.

Optional Feature:
- Macro: FMD_SEQ_ABORT_EN.
- Defined: adds input abort (1 bit). abort=1 in any non-IDLE state forces IDLE on the next edge, with no done and all *_we low in that cycle and after. If abort and start are both high in IDLE, start wins.
- Not defined: no abort port. An operation always runs to DONE.

Test Plan:
- Multiply: start=1, fdiv=0 -> a_sel=2, b_sel=0 for 2 cycles; fq_we high only in cycle 2; done high at edge 3; busy low afterward.
- SP divide: fdiv=1, db=0 -> NR_A/NR_X pairs occur 2 times; x_we pulses 2; iter_left 2->1->0; done at edge 15; oe1/oe2 sequence 11/0,10/1,01/1,01/0,00/0.
- DP divide: fdiv=1, db=1 -> 3 iterations, 3 x_we pulses, done at edge 19; first NR_A and NR_X use a_sel=0, later ones a_sel=1.
- Busy rejection: second start at edge 5 of a divide, with fdiv flipped to 0 -> ignored; done still at 15; exactly one done pulse.
- Reset mid-op: reset at edge 8 of a DP divide -> all outputs zero by next edge, no done; new multiply start completes in 3.
- Abort (FMD_SEQ_ABORT_EN): abort at edge 6 -> IDLE at edge 7, no done, no further we pulses; without the macro, the same bench compiles without the abort drive.
